// File: rtl/mac_gate_ctrl.sv
// mac_gate_ctrl: registers operand beats and drives per-lane isolation-latch enables,
// with idle sleep and a fixed wake delay. Zero-lane skipping is built when MAC_ZERO_SKIP_EN is defined.
module mac_gate_ctrl #(
  parameter int bw       = 8,
  parameter int col      = 8,
  parameter int IDLE_CYC = 4,
  parameter int WAKE_CYC = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [col*bw-1:0]   in_x,
  input  logic [col*bw-1:0]   in_w,
  output logic [col*bw-1:0]   x_q,
  output logic [col*bw-1:0]   w_q,
  output logic [col-1:0]      lane_en,
  output logic                out_valid,
  output logic [col-1:0]      zero_mask,
  output logic                asleep,
  output logic [15:0]         skip_cnt
);

  localparam int IdleW = $clog2(IDLE_CYC + 1);
  localparam int WakeW = $clog2(WAKE_CYC + 1);

  typedef enum logic [1:0] {SLEEP, WAKE, ACTIVE} state_t;

  state_t            state_q;
  logic [IdleW-1:0]  idle_q;
  logic [WakeW-1:0]  wake_q;
  logic              out_valid_q;
  logic [col-1:0]    lane_en_q;
  logic [col-1:0]    zero_mask_q;
  logic [col-1:0]    skip_d;
  logic              accept;

  assign in_ready  = (state_q == ACTIVE);
  assign asleep    = (state_q == SLEEP);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign lane_en   = lane_en_q;
  assign zero_mask = zero_mask_q;

`ifdef MAC_ZERO_SKIP_EN
  localparam int PopW = $clog2(col + 1);

  logic [15:0]     skip_cnt_q;
  logic [15:0]     skip_cnt_d;
  logic [16:0]     skip_sum;
  logic [PopW-1:0] skip_pop;

  // A lane whose product is provably zero keeps its latch closed.
  always_comb begin
    skip_d   = '0;
    skip_pop = '0;
    for (int i = 0; i < col; i++) begin
      skip_d[i] = (in_x[i*bw +: bw] == '0) || (in_w[i*bw +: bw] == '0);
      skip_pop  = skip_pop + PopW'(skip_d[i]);
    end
    skip_sum   = {1'b0, skip_cnt_q} + 17'(skip_pop);
    skip_cnt_d = skip_sum[16] ? 16'hFFFF : skip_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      skip_cnt_q <= '0;
    end else if (accept) begin
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign skip_cnt = skip_cnt_q;
`else
  assign skip_d   = '0;
  assign skip_cnt = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SLEEP;
      idle_q      <= '0;
      wake_q      <= '0;
      out_valid_q <= 1'b0;
      lane_en_q   <= '0;
      zero_mask_q <= '0;
      x_q         <= '0;
      w_q         <= '0;
    end else begin
      out_valid_q <= accept;
      lane_en_q   <= accept ? ~skip_d : '0;
      zero_mask_q <= accept ? skip_d : '0;
      if (accept) begin
        x_q <= in_x;
        w_q <= in_w;
      end
      // An accept in the threshold cycle takes priority over going to sleep.
      unique case (state_q)
        SLEEP: begin
          if (in_valid) begin
            state_q <= WAKE;
            wake_q  <= '0;
          end
        end
        WAKE: begin
          if (wake_q == WakeW'(WAKE_CYC - 1)) begin
            state_q <= ACTIVE;
            idle_q  <= '0;
          end else begin
            wake_q <= wake_q + WakeW'(1);
          end
        end
        ACTIVE: begin
          if (accept) begin
            idle_q <= '0;
          end else if (idle_q == IdleW'(IDLE_CYC - 1)) begin
            state_q <= SLEEP;
            idle_q  <= '0;
          end else begin
            idle_q <= idle_q + IdleW'(1);
          end
        end
        default: state_q <= SLEEP;
      endcase
    end
  end

endmodule
